mem_arbiter: RTL and testbench

- Two-requester arbiter for the single-port program/data memory shared by the CPU controller (port 0) and the program loader/debug port (port 1).
- Each access is serialised into a fixed sequence: grant, access, optional wait states, acknowledge.
- Ties are resolved round-robin, so neither port starves.
- Sits between the requesters and the memory's addr/data/rd/wr pins.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// Each access runs grant -> access -> optional wait states -> acknowledge.
module mem_arbiter #(
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_t;

    state_t        state;
    logic          owner;
    logic          last;
    logic          lat_we;
    logic [2:0]    cnt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          pick;

    // Winner of the IDLE-state arbitration; a tie goes to the port that did not go last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else begin
            pick = req1;
        end
    end

    // Transaction sequencer with its latched request and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            cnt       <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        owner     <= pick;
                        lat_we    <= pick ? we1 : we0;
                        lat_addr  <= pick ? addr1 : addr0;
                        lat_wdata <= pick ? wdata1 : wdata0;
                        state     <= StAccess;
                    end
                end
                StAccess: begin
                    if (lat_we || (MEM_LAT == 1)) begin
                        if (!lat_we) begin
                            rdata <= mem_rdata;
                        end
                        state <= StDone;
                    end else begin
                        // Remaining wait cycles after this one and the final capture cycle.
                        cnt   <= 3'(MEM_LAT - 2);
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (cnt == 3'd0) begin
                        rdata <= mem_rdata;
                        state <= StDone;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StDone: begin
                    last  <= owner;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Handshake and memory strobes decoded from state so reset clears them at once.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state != StIdle);
        if (state != StIdle) begin
            gnt0 = ~owner;
            gnt1 = owner;
        end
        case (state)
            StAccess: begin
                mem_wr    = lat_we;
                mem_rd    = ~lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            StWait: begin
                mem_rd    = 1'b1;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            StDone: begin
                ack0 = ~owner;
                ack1 = owner;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic clk;
    logic rst;

    // MEM_LAT = 1 instance
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1, busy, mem_rd, mem_wr;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    // MEM_LAT = 3 instance
    logic          req0_b, we0_b, req1_b, we1_b;
    logic [AW-1:0] addr0_b, addr1_b;
    logic [DW-1:0] wdata0_b, wdata1_b;
    logic          gnt0_b, gnt1_b, ack0_b, ack1_b, busy_b, mem_rd_b, mem_wr_b;
    logic [DW-1:0] rdata_b, mem_wdata_b, mem_rdata_b;
    logic [AW-1:0] mem_addr_b;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b),
        .rdata(rdata_b), .busy(busy_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_rdata(mem_rdata_b)
    );

    // Memory models: read data is only valid once mem_rd has been held for the
    // full latency, otherwise a poison value 8'hEE is returned.
    logic [DW-1:0] mem1 [32];
    logic [DW-1:0] mem3 [32];
    int rd_cnt1 = 0;
    int rd_cnt3 = 0;

    always @(posedge clk) begin
        if (mem_wr) mem1[mem_addr] <= mem_wdata;
        rd_cnt1 <= mem_rd ? rd_cnt1 + 1 : 0;
    end
    always @(posedge clk) begin
        if (mem_wr_b) mem3[mem_addr_b] <= mem_wdata_b;
        rd_cnt3 <= mem_rd_b ? rd_cnt3 + 1 : 0;
    end
    assign mem_rdata   = (mem_rd && rd_cnt1 == 0) ? mem1[mem_addr] : 8'hEE;
    assign mem_rdata_b = (mem_rd_b && rd_cnt3 == 2) ? mem3[mem_addr_b] : 8'hEE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic exp_port;
        logic got;

        rst = 1'b1;
        {req0, we0, req1, we1} = '0;
        {req0_b, we0_b, req1_b, we1_b} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[3]  = 8'hA5;
        mem3[10] = 8'h5A;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_ack", {ack0, ack1}, 0);
        check("rst_strobes", {mem_rd, mem_wr}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        step();
        rst = 1'b0;

        // Single read by port 0, MEM_LAT=1
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h03;
        check("rd_pre_gnt0", gnt0, 0);
        step();
        check("rd_gnt0", gnt0, 1);
        check("rd_mem_rd", mem_rd, 1);
        check("rd_mem_addr", mem_addr, 5'h03);
        check("rd_ack_early", ack0, 0);
        step();
        check("rd_ack0", ack0, 1);
        check("rd_rdata", rdata, 8'hA5);
        check("rd_mem_rd_off", mem_rd, 0);
        req0 = 1'b0;
        step();
        check("rd_busy_idle", busy, 0);
        check("rd_ack0_pulse", ack0, 0);

        // Port 1 write
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h1F; wdata1 = 8'h3C;
        step();
        check("wr_gnt1", {gnt0, gnt1}, 2'b01);
        check("wr_mem_wr", {mem_wr, mem_rd}, 2'b10);
        check("wr_mem_addr", mem_addr, 5'h1F);
        check("wr_mem_wdata", mem_wdata, 8'h3C);
        step();
        check("wr_ack1", {ack0, ack1}, 2'b01);
        check("wr_mem_wr_off", mem_wr, 0);
        check("wr_rdata_kept", rdata, 8'hA5);
        req1 = 1'b0;
        step();
        check("wr_ack1_pulse", ack1, 0);

        // Readback by port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h1F;
        step();
        step();
        check("rb_ack0", ack0, 1);
        check("rb_rdata", rdata, 8'h3C);
        req0 = 1'b0;
        step();

        // Simultaneous requests after reset: 0,1,0,1
        rst = 1'b1;
        #2 rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h03;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h1F;
        for (int k = 0; k < 4; k++) begin
            exp_port = k[0];
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                step();
                check("tie_gnt_excl", gnt0 & gnt1, 0);
                if (ack0 || ack1) begin
                    got = 1'b1;
                    check("tie_ack", {ack0, ack1}, exp_port ? 2'b01 : 2'b10);
                    check("tie_gnt", {gnt0, gnt1}, exp_port ? 2'b01 : 2'b10);
                    check("tie_rdata", rdata, exp_port ? 8'h3C : 8'hA5);
                end
            end
            check("tie_ack_seen", got, 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        check("tie_busy_idle", busy, 0);

        // MEM_LAT=3 read by port 1
        req1_b = 1'b1; we1_b = 1'b0; addr1_b = 5'h0A;
        for (int i = 0; i < 3; i++) begin
            step();
            check("lat3_mem_rd", mem_rd_b, 1);
            check("lat3_mem_addr", mem_addr_b, 5'h0A);
            check("lat3_ack_early", ack1_b, 0);
            check("lat3_gnt1", gnt1_b, 1);
        end
        step();
        check("lat3_ack1", ack1_b, 1);
        check("lat3_rdata", rdata_b, 8'h5A);
        check("lat3_mem_rd_off", mem_rd_b, 0);
        req1_b = 1'b0;
        step();
        check("lat3_busy_idle", busy_b, 0);

        // Port 0 read so that port 0 went last before the aborted transaction
        req0_b = 1'b1; we0_b = 1'b0; addr0_b = 5'h0A;
        repeat (4) step();
        check("lat3_ack0", ack0_b, 1);
        req0_b = 1'b0;
        step();

        // Reset during WAIT of a port 1 read
        req1_b = 1'b1; we1_b = 1'b0; addr1_b = 5'h0A;
        step();
        step();
        check("abort_in_wait", {busy_b, mem_rd_b, gnt1_b}, 3'b111);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_rd", mem_rd_b, 0);
        check("abort_gnt", {gnt0_b, gnt1_b}, 0);
        check("abort_busy", busy_b, 0);
        check("abort_ack", {ack0_b, ack1_b}, 0);
        req1_b = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("abort_no_ack", {ack0_b, ack1_b}, 0);
        check("abort_idle", busy_b, 0);

        // First tie after reset goes to port 0
        req0_b = 1'b1; we0_b = 1'b1; addr0_b = 5'h10; wdata0_b = 8'h11;
        req1_b = 1'b1; we1_b = 1'b1; addr1_b = 5'h11; wdata1_b = 8'h22;
        step();
        check("post_rst_tie_gnt", {gnt0_b, gnt1_b}, 2'b10);
        step();
        check("post_rst_tie_ack", {ack0_b, ack1_b}, 2'b10);
        req0_b = 1'b0; req1_b = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
